// File: rtl/nl2_dbank_cmd_arb.sv
// NL2 data bank command arbiter: merges AXI AR/AW onto the single bank command port,
// one command per beat, read/write round-robin at burst granularity.
module nl2_dbank_cmd_arb #(
  parameter int CMD_ID_SIZE   = 1,
  parameter int WR_ID_SIZE    = 1,
  parameter int CMD_ADDR_SIZE = 32,
  parameter int LEN_SIZE      = 4,
  parameter int BEAT_LOG2     = 4,
  localparam int ID_W = (CMD_ID_SIZE > WR_ID_SIZE) ? CMD_ID_SIZE : WR_ID_SIZE
) (
  input  logic                     axi_clk,
  input  logic                     rst_a,
  input  logic                     axi_arvalid,
  output logic                     axi_arready,
  input  logic [CMD_ID_SIZE-1:0]   axi_arid,
  input  logic [CMD_ADDR_SIZE-1:0] axi_araddr,
  input  logic [LEN_SIZE-1:0]      axi_arlen,
  input  logic                     axi_arlock,
  input  logic                     axi_awvalid,
  output logic                     axi_awready,
  input  logic [WR_ID_SIZE-1:0]    axi_awid,
  input  logic [CMD_ADDR_SIZE-1:0] axi_awaddr,
  input  logic [LEN_SIZE-1:0]      axi_awlen,
  input  logic                     axi_awlock,
  input  logic [1:0]               excl_err,
  output logic                     cmd_valid,
  input  logic                     cmd_accept,
  output logic                     cmd_read,
  output logic [CMD_ADDR_SIZE-1:0] cmd_addr,
  output logic [ID_W-1:0]          cmd_id,
  output logic                     cmd_excl,
  output logic                     cmd_excl_fail,
  output logic                     cmd_last
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_RD     = 2'd1;
  localparam logic [1:0]  S_WR     = 2'd2;
  localparam logic [11:0] ADDR_INC = 12'(1 << BEAT_LOG2);

  logic [1:0]               state_q, state_d;
  logic                     last_wr_q, last_wr_d;
  logic [LEN_SIZE-1:0]      cnt_q, cnt_d;
  logic [CMD_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [ID_W-1:0]          id_q, id_d;
  logic                     read_q, read_d;
  logic                     excl_q, excl_d;
  logic                     fail_q, fail_d;
  logic                     grant_rd, grant_wr;

  // Only the fail bit of the monitor verdict matters here.
  logic unused_excl_err;
  assign unused_excl_err = excl_err[0];

  assign grant_rd = axi_arvalid & (~axi_awvalid | last_wr_q);
  assign grant_wr = axi_awvalid & (~axi_arvalid | ~last_wr_q);

  always_comb begin
    state_d     = state_q;
    last_wr_d   = last_wr_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    id_d        = id_q;
    read_d      = read_q;
    excl_d      = excl_q;
    fail_d      = fail_q;
    axi_arready = 1'b0;
    axi_awready = 1'b0;
    case (state_q)
      S_IDLE: begin
        axi_arready = grant_rd;
        axi_awready = grant_wr;
        if (grant_rd) begin
          state_d                = S_RD;
          last_wr_d              = 1'b0;
          cnt_d                  = axi_arlen;
          addr_d                 = axi_araddr;
          id_d                   = '0;
          id_d[CMD_ID_SIZE-1:0]  = axi_arid;
          read_d                 = 1'b1;
          excl_d                 = axi_arlock;
          fail_d                 = 1'b0;
        end else if (grant_wr) begin
          state_d                = S_WR;
          last_wr_d              = 1'b1;
          cnt_d                  = axi_awlen;
          addr_d                 = axi_awaddr;
          id_d                   = '0;
          id_d[WR_ID_SIZE-1:0]   = axi_awid;
          read_d                 = 1'b0;
          excl_d                 = axi_awlock;
          fail_d                 = axi_awlock & excl_err[1];
        end
      end
      S_RD, S_WR: begin
        if (cmd_accept) begin
          if (cnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d        = cnt_q - LEN_SIZE'(1);
            // Increment wraps inside the 4 KB page; upper bits never change.
            addr_d[11:0] = addr_q[11:0] + ADDR_INC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or posedge rst_a) begin
    if (rst_a) begin
      state_q   <= S_IDLE;
      last_wr_q <= 1'b1;
      cnt_q     <= '0;
      addr_q    <= '0;
      id_q      <= '0;
      read_q    <= 1'b0;
      excl_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      read_q    <= read_d;
      excl_q    <= excl_d;
      fail_q    <= fail_d;
    end
  end

  assign cmd_valid     = (state_q != S_IDLE);
  assign cmd_read      = read_q;
  assign cmd_addr      = addr_q;
  assign cmd_id        = id_q;
  assign cmd_excl      = excl_q;
  assign cmd_excl_fail = fail_q;
  assign cmd_last      = cmd_valid & (cnt_q == '0);

endmodule

// File: tb/tb_nl2_dbank_cmd_arb.sv
// Bench for nl2_dbank_cmd_arb: directed and random bursts compared against a
// transaction-level model of the expected beat sequence.
module tb_nl2_dbank_cmd_arb;
  localparam int CIS = 4;
  localparam int WIS = 2;

  logic        axi_clk = 1'b0;
  logic        rst_a;
  logic        axi_arvalid, axi_arready, axi_arlock;
  logic [3:0]  axi_arid;
  logic [31:0] axi_araddr;
  logic [3:0]  axi_arlen;
  logic        axi_awvalid, axi_awready, axi_awlock;
  logic [1:0]  axi_awid;
  logic [31:0] axi_awaddr;
  logic [3:0]  axi_awlen;
  logic [1:0]  excl_err;
  logic        cmd_valid, cmd_accept, cmd_read, cmd_excl, cmd_excl_fail, cmd_last;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_id;

  int n_assert = 0;
  int n_fail   = 0;
  bit last_wr_model;

  nl2_dbank_cmd_arb #(.CMD_ID_SIZE(CIS), .WR_ID_SIZE(WIS), .CMD_ADDR_SIZE(32),
                      .LEN_SIZE(4), .BEAT_LOG2(4)) dut (
    .axi_clk(axi_clk), .rst_a(rst_a),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arlock(axi_arlock),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awlock(axi_awlock),
    .excl_err(excl_err), .cmd_valid(cmd_valid), .cmd_accept(cmd_accept),
    .cmd_read(cmd_read), .cmd_addr(cmd_addr), .cmd_id(cmd_id), .cmd_excl(cmd_excl),
    .cmd_excl_fail(cmd_excl_fail), .cmd_last(cmd_last)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, cmd_valid, 0);
    chk({tag, "_read"}, cmd_read, 0);
    chk({tag, "_addr"}, cmd_addr, 0);
    chk({tag, "_id"}, cmd_id, 0);
    chk({tag, "_excl"}, cmd_excl, 0);
    chk({tag, "_fail"}, cmd_excl_fail, 0);
    chk({tag, "_last"}, cmd_last, 0);
    chk({tag, "_arready"}, axi_arready, 0);
    chk({tag, "_awready"}, axi_awready, 0);
  endtask

  task automatic do_reset();
    rst_a = 1'b1;
    axi_arvalid = 0; axi_awvalid = 0; cmd_accept = 0; excl_err = 0;
    axi_arid = 0; axi_araddr = 0; axi_arlen = 0; axi_arlock = 0;
    axi_awid = 0; axi_awaddr = 0; axi_awlen = 0; axi_awlock = 0;
    repeat (2) @(posedge axi_clk);
    @(negedge axi_clk);
    check_idle_outputs("reset");
    rst_a = 1'b0;
    last_wr_model = 1'b1;
    @(posedge axi_clk); #1;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of the bubble cycle.
  task automatic do_cmd(input bit rd, input logic [31:0] addr, input int len, input bit lock,
                        input logic [1:0] err, input logic [3:0] id, input bit rnd_acc,
                        input int stall_beat, input int stall_n);
    logic [11:0] lo;
    logic [3:0]  exp_id;
    bit          acc;
    int          stalls;
    exp_id = rd ? id : {2'b00, id[1:0]};
    if (rd) begin
      axi_arvalid = 1; axi_araddr = addr; axi_arlen = len[3:0]; axi_arlock = lock; axi_arid = id;
    end else begin
      axi_awvalid = 1; axi_awaddr = addr; axi_awlen = len[3:0]; axi_awlock = lock;
      axi_awid = id[1:0]; excl_err = err;
    end
    @(negedge axi_clk);
    chk("hs_arready", axi_arready, rd);
    chk("hs_awready", axi_awready, !rd);
    chk("hs_valid", cmd_valid, 0);
    @(posedge axi_clk); #1;
    axi_arvalid = 0; axi_awvalid = 0;
    excl_err = {~err[1], err[0]};
    for (int b = 0; b <= len; b++) begin
      lo = addr[11:0] + 12'(b * 16);
      stalls = 0;
      forever begin
        if (b == stall_beat && stalls < stall_n) acc = 0;
        else if (rnd_acc && stalls < 4) acc = ($urandom_range(0, 2) != 0);
        else acc = 1;
        cmd_accept = acc;
        @(negedge axi_clk);
        chk("beat_valid", cmd_valid, 1);
        chk("beat_read", cmd_read, rd);
        chk("beat_addr", cmd_addr, {addr[31:12], lo});
        chk("beat_last", cmd_last, (b == len));
        chk("beat_id", cmd_id, exp_id);
        chk("beat_excl", cmd_excl, lock);
        chk("beat_fail", cmd_excl_fail, (!rd && lock && err[1]));
        chk("beat_arready", axi_arready, 0);
        chk("beat_awready", axi_awready, 0);
        @(posedge axi_clk); #1;
        if (acc) break;
        stalls++;
      end
    end
    cmd_accept = 0;
    last_wr_model = !rd;
    chk("post_valid", cmd_valid, 0);
  endtask

  task automatic contention(input int rounds);
    bit exp_rd;
    axi_arvalid = 1; axi_araddr = 32'h0000_5000; axi_arlen = 0; axi_arlock = 0; axi_arid = 4'h9;
    axi_awvalid = 1; axi_awaddr = 32'h0000_6000; axi_awlen = 0; axi_awlock = 0; axi_awid = 2'h2;
    excl_err = 0;
    cmd_accept = 1;
    for (int k = 0; k < rounds; k++) begin
      exp_rd = last_wr_model;
      @(negedge axi_clk);
      chk("rr_arready", axi_arready, exp_rd);
      chk("rr_awready", axi_awready, !exp_rd);
      chk("rr_idle", cmd_valid, 0);
      @(posedge axi_clk); #1;
      @(negedge axi_clk);
      chk("rr_valid", cmd_valid, 1);
      chk("rr_read", cmd_read, exp_rd);
      chk("rr_addr", cmd_addr, exp_rd ? 32'h0000_5000 : 32'h0000_6000);
      chk("rr_last", cmd_last, 1);
      last_wr_model = !exp_rd;
      @(posedge axi_clk); #1;
    end
    axi_arvalid = 0; axi_awvalid = 0; cmd_accept = 0;
  endtask

  initial begin
    rst_a = 1'b1;
    do_reset();
    contention(6);

    do_cmd(1, 32'h0000_1000, 3, 0, 2'b00, 4'hA, 0, -1, 0);
    do_cmd(0, 32'h0000_3400, 1, 1, 2'b10, 4'h3, 0, -1, 0);
    do_cmd(0, 32'h0000_3400, 1, 1, 2'b00, 4'h1, 0, -1, 0);
    do_cmd(0, 32'h0000_3800, 2, 0, 2'b10, 4'h2, 1, -1, 0);
    do_cmd(1, 32'h0000_4000, 2, 0, 2'b00, 4'h5, 0, 1, 5);
    do_cmd(1, 32'h0000_2FF0, 1, 0, 2'b00, 4'hF, 0, -1, 0);

    for (int t = 0; t < 25; t++) begin
      logic [31:0] a;
      a = $urandom;
      a[3:0] = 4'h0;
      do_cmd(bit'($urandom_range(0, 1)), a, $urandom_range(0, 15), bit'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1, -1, 0);
    end

    // Abort a len=7 write during its third beat.
    axi_awvalid = 1; axi_awaddr = 32'h0000_7100; axi_awlen = 4'd7; axi_awlock = 1;
    axi_awid = 2'h3; excl_err = 2'b10;
    @(posedge axi_clk); #1;
    axi_awvalid = 0; cmd_accept = 1;
    repeat (2) begin @(posedge axi_clk); #1; end
    cmd_accept = 0;
    @(negedge axi_clk);
    chk("abort_pre_valid", cmd_valid, 1);
    chk("abort_pre_addr", cmd_addr, 32'h0000_7120);
    #1 rst_a = 1'b1;
    #1;
    check_idle_outputs("abort");
    @(negedge axi_clk);
    rst_a = 1'b0;
    last_wr_model = 1'b1;
    @(posedge axi_clk); #1;
    do_cmd(1, 32'h0000_8000, 0, 0, 2'b00, 4'h6, 0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
